// File: rtl/cone_sweep_ctrl.sv
// Exhaustive sweep controller: drives every NIN-bit vector to a DUT cone and a
// golden cone, waits a settle window, then accumulates mismatch statistics.
module cone_sweep_ctrl #(
  parameter int NIN    = 4,
  parameter int NOUT   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [NIN-1:0]  stim,
  input  logic [NOUT-1:0] dut_resp,
  input  logic [NOUT-1:0] gold_resp,
  output logic            busy,
  output logic            done,
  output logic            any_fail,
  output logic [NIN:0]    fail_cnt,
  output logic [NIN-1:0]  first_fail,
  output logic [NOUT-1:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [NIN-1:0]  stim_q, stim_d;
  logic [3:0]      settle_q, settle_d;
  logic            any_fail_q, any_fail_d;
  logic [NIN:0]    fail_cnt_q, fail_cnt_d;
  logic [NIN-1:0]  first_fail_q, first_fail_d;
  logic [NOUT-1:0] fail_mask_q, fail_mask_d;
  logic [NOUT-1:0] diff;

  assign diff = dut_resp ^ gold_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stim_q       <= '0;
      settle_q     <= '0;
      any_fail_q   <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_mask_q  <= '0;
    end else begin
      state_q      <= state_d;
      stim_q       <= stim_d;
      settle_q     <= settle_d;
      any_fail_q   <= any_fail_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      fail_mask_q  <= fail_mask_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stim_d       = stim_q;
    settle_d     = settle_q;
    any_fail_d   = any_fail_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    fail_mask_d  = fail_mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_SETTLE;
          stim_d       = '0;
          settle_d     = SETTLE_INIT;
          any_fail_d   = 1'b0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          fail_mask_d  = '0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == 4'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      S_CHECK: begin
        // An aborted compare must leave the partial results untouched.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (diff != '0) begin
            fail_cnt_d  = fail_cnt_q + (NIN+1)'(1);
            fail_mask_d = fail_mask_q | diff;
            if (!any_fail_q) begin
              first_fail_d = stim_q;
              any_fail_d   = 1'b1;
            end
          end
          if (stim_q == '1) begin
            state_d = S_DONE;
          end else begin
            stim_d   = stim_q + NIN'(1);
            settle_d = SETTLE_INIT;
            state_d  = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stim       = stim_q;
  assign busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign any_fail   = any_fail_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;
  assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_cone_sweep_ctrl.sv
// Directed bench for cone_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// driving a behavioural golden cone and an optionally faulted copy.
module tb_cone_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, abort1, start3, abort3;
  logic       fault1;
  logic [3:0] stim1, stim3;
  logic [1:0] dut1, gold1, dut3, gold3;
  logic       busy1, done1, any1, busy3, done3, any3;
  logic [4:0] cnt1, cnt3;
  logic [3:0] first1, first3;
  logic [1:0] mask1, mask3;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int pulses;

  always #5 clk = ~clk;

  function automatic logic [1:0] cone(input logic [3:0] i);
    logic o0, o1;
    o0 = i[0] & i[1];
    o1 = (i[2] & i[0]) | (i[1] & (~i[0] | i[3]));
    return {o1, o0};
  endfunction

  always_comb begin
    gold1 = cone(stim1);
    dut1  = cone(stim1);
    if (fault1) dut1[0] = 1'b0;
    gold3 = cone(stim3);
    dut3  = cone(stim3);
  end

  cone_sweep_ctrl #(.NIN(4), .NOUT(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .stim(stim1),
    .dut_resp(dut1), .gold_resp(gold1), .busy(busy1), .done(done1),
    .any_fail(any1), .fail_cnt(cnt1), .first_fail(first1), .fail_mask(mask1)
  );

  cone_sweep_ctrl #(.NIN(4), .NOUT(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .stim(stim3),
    .dut_resp(dut3), .gold_resp(gold3), .busy(busy3), .done(done3),
    .any_fail(any3), .fail_cnt(cnt3), .first_fail(first3), .fail_mask(mask3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start1 for one edge (edge 0), then counts edges until done1.
  task automatic sweep1(input int limit, output int n);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (done1) break;
    end
  endtask

  task automatic results1(input string tag, input int cnt, input int first,
                          input int mask, input int anyf);
    chk({tag, "_cnt"},   cnt1,   cnt);
    chk({tag, "_first"}, first1, first);
    chk({tag, "_mask"},  mask1,  mask);
    chk({tag, "_any"},   any1,   anyf);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    fault1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_stim", stim1, 0);
    results1("rst", 0, 0, 0, 0);

    // Matched cones.
    sweep1(40, cyc);
    chk("t1_latency", cyc, 32);
    chk("t1_done", done1, 1);
    results1("t1", 0, 0, 0, 0);
    tick();
    chk("t1_done_width", done1, 0);
    chk("t1_idle_busy", busy1, 0);

    // out0 stuck-at-0.
    fault1 = 1'b1;
    sweep1(40, cyc);
    chk("t2_latency", cyc, 32);
    results1("t2", 4, 3, 1, 1);
    chk("t2_stim_end", stim1, 15);
    tick();
    chk("t2_done_width", done1, 0);
    for (int k = 0; k < 3; k++) tick();
    results1("t2_hold", 4, 3, 1, 1);

    // Abort during CHECK of vector 5 (after edge 11).
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    results1("t3_clear", 0, 0, 0, 0);
    for (int k = 0; k < 11; k++) tick();
    chk("t3_stim5", stim1, 5);
    chk("t3_busy_check", busy1, 1);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("t3_busy", busy1, 0);
    chk("t3_done", done1, 0);
    chk("t3_stim_hold", stim1, 5);
    results1("t3", 1, 3, 1, 1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done1) pulses++;
    end
    chk("t3_no_done", pulses, 0);
    results1("t3_hold", 1, 3, 1, 1);
    sweep1(40, cyc);
    chk("t3_rerun_latency", cyc, 32);
    results1("t3_rerun", 4, 3, 1, 1);
    tick();

    // SETTLE=3: each vector held 4 cycles, done after edge 64.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    chk("t4_stim_e0", stim3, 0);
    cyc = 0;
    while (cyc < 80) begin
      tick();
      cyc++;
      if (done3) break;
      if (cyc < 64) chk($sformatf("t4_stim_e%0d", cyc), stim3, cyc / 4);
    end
    chk("t4_latency", cyc, 64);
    chk("t4_cnt", cnt3, 0);
    chk("t4_any", any3, 0);
    tick();
    chk("t4_done_width", done3, 0);

    // start held high, with a low/high toggle around cycle 10.
    fault1 = 1'b0;
    start1 = 1'b1;
    tick();
    pulses = 0;
    for (int k = 1; k <= 33; k++) begin
      if (k == 9) start1 = 1'b0;
      if (k == 10) start1 = 1'b1;
      tick();
      if (done1) begin
        pulses++;
        chk("t5_done_edge", k, 32);
      end
      if (k == 20) chk("t5_busy_mid", busy1, 1);
    end
    chk("t5_pulses", pulses, 1);
    chk("t5_done_low", done1, 0);
    chk("t5_idle", busy1, 0);
    tick();
    chk("t5_restart_busy", busy1, 1);
    chk("t5_restart_stim", stim1, 0);
    start1 = 1'b0;
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("t5_abort_idle", busy1, 0);

    // Reset at cycle 12 of a failing sweep.
    fault1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("t6_pre_stim", stim1, 6);
    results1("t6_pre", 1, 3, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy1, 0);
    chk("t6_done", done1, 0);
    chk("t6_stim", stim1, 0);
    results1("t6_rst", 0, 0, 0, 0);
    tick();
    chk("t6_stay_idle", busy1, 0);
    fault1 = 1'b0;
    sweep1(40, cyc);
    chk("t6_latency", cyc, 32);
    results1("t6_clean", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cone_sweep_ctrl.md
Name: cone_sweep_ctrl

Overview:
Sequential test controller that exhaustively sweeps all 2^NIN input vectors through a small combinational cone under test, such as a 4-input/2-output matching-benchmark netlist. For each vector it waits a settle window, then compares the cone's response against a golden cone driven by the same vector. It accumulates a failure count, the first failing vector and a per-output failure mask. It sits between a bench or top-level sequencer (start/abort) and the shared stimulus bus feeding both cones.

Parameters:
NIN, 4, number of cone inputs; sweep covers vectors 0..2^NIN-1
NOUT, 2, number of cone outputs compared
SETTLE, 1, cycles each vector is held before comparison (legal range 1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  terminate a sweep in progress
stim  output  NIN  vector driven to both DUT and golden cone; stim[0] drives cone input 0
dut_resp  input  NOUT  DUT cone outputs
gold_resp  input  NOUT  golden cone outputs
busy  output  1  high in SETTLE and CHECK
done  output  1  one-cycle pulse on sweep completion (not on abort)
any_fail  output  1  at least one mismatch in last or current sweep
fail_cnt  output  NIN+1  number of failing vectors
first_fail  output  NIN  lowest failing vector; 0 if none
fail_mask  output  NOUT  OR over all vectors of (dut_resp ^ gold_resp)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset, on a clk edge with rst=1, takes priority over everything:
  - state=IDLE
  - stim=0, busy=0, done=0, any_fail=0, fail_cnt=0, first_fail=0, fail_mask=0
  - settle counter=0
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 and abort=0 → SETTLE.
  - On that transition: stim=0, settle counter=SETTLE-1, clear any_fail, fail_cnt, first_fail and fail_mask.
  - start=1 with abort=1 in the same cycle: start is ignored.
- SETTLE:
  - abort=1 → IDLE.
  - Else if settle counter=0 → CHECK.
  - Else decrement the settle counter.
  - stim is held constant.
- CHECK, one cycle; diff = dut_resp ^ gold_resp, sampled this cycle:
  - abort=1 → IDLE; the compare is discarded.
  - If diff!=0:
    - fail_cnt+1
    - fail_mask |= diff
    - if any_fail was 0: first_fail=stim and any_fail=1
  - If stim is all ones → DONE; stim is held.
  - Else stim+1, settle counter=SETTLE-1, → SETTLE.
- DONE: done=1 for exactly this cycle, → IDLE unconditionally. abort is ignored here.
- Abort: results hold their partial values; stim holds its last value; done is not asserted.
- start while busy or in DONE: ignored, with no effect on the sweep in progress.
- Latency and timing:
  - Each vector occupies SETTLE+1 cycles.
  - With start sampled at edge 0, done is high in the cycle after edge 2^NIN*(SETTLE+1).
  - NIN=4, SETTLE=1: done rises after edge 32.
- Counter width:
  - fail_cnt saturates naturally because its maximum is 2^NIN, which fits in NIN+1 bits.
  - stim increments never wrap inside a sweep.
- Result holding: results remain stable in IDLE until the next accepted start or reset.
- Reset mid-sweep: immediate return to IDLE with all outputs at their reset values; no done pulse.

Test Plan:
1. Matched cones, NIN=4, SETTLE=1:
   - Stimulus: DUT and golden both implement out0=i0&i1 and out1=(i2&i0)|(i1&(~i0|i3)); pulse start.
   - Required response: done after 32 edges, fail_cnt=0, any_fail=0, first_fail=0, fail_mask=00.
2. DUT out0 stuck-at-0, otherwise as test 1:
   - Stimulus: full sweep.
   - Required response: failures at vectors 3, 7, 11, 15 → fail_cnt=4, first_fail=3, fail_mask=01, any_fail=1, one done pulse.
3. Abort mid-sweep, fault as test 2:
   - Stimulus: assert abort during CHECK of vector 5.
   - Required response: IDLE next cycle, no done, fail_cnt=1, first_fail=3, busy=0.
   - Then pulse start: results cleared and a full 32-cycle sweep completes with fail_cnt=4.
4. SETTLE=3:
   - Stimulus: matched cones.
   - Required response: each stim value held 4 cycles; done after 64 edges.
5. start held high throughout a sweep plus an extra pulse at cycle 10:
   - Required response: exactly one sweep, done pulse width 1.
   - Because start is still high in IDLE after DONE, a second sweep begins the cycle after IDLE is re-entered.
6. rst asserted at cycle 12 of a failing sweep:
   - Required response: next cycle all outputs 0 and state IDLE.
   - A following start runs a clean full sweep.
